// File: rtl/morse_symbol_sequencer.sv
// Morse front-end: times key press/release in units, builds letters, writes letters and word spaces.
// Optional MORSE_DROP_CNT_EN adds the drop_cnt port counting writes lost to wr_full.
//
// state | meaning
// IDLE  | key released, no letter pending
// PRESS | key held, timing the current symbol
// GAP   | key released inside a letter, waiting for the letter gap
// WGAP  | letter emitted, waiting for the word gap or the next press
module morse_symbol_sequencer #(
    parameter int TIMER_FINAL_VALUE = 5,
    parameter int DASH_MIN_UNITS    = 2,
    parameter int LETTER_GAP_UNITS  = 3,
    parameter int WORD_GAP_UNITS    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b,
    input  logic       wr_full,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       busy
`ifdef MORSE_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int TW = (TIMER_FINAL_VALUE > 0) ? $clog2(TIMER_FINAL_VALUE + 1) : 1;
    localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMER_FINAL_VALUE);
    localparam logic [3:0]    DASH_MIN   = 4'(DASH_MIN_UNITS);
    localparam logic [3:0]    LETTER_GAP = 4'(LETTER_GAP_UNITS);
    localparam logic [3:0]    WORD_GAP   = 4'(WORD_GAP_UNITS);
    localparam logic [3:0]    UNIT_MAX   = 4'd15;
    localparam logic [7:0]    ERR_WORD   = 8'hE0;
    localparam logic [7:0]    SPACE_WORD = 8'h00;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] WGAP  = 2'd3;

    logic [1:0]    state;
    logic          b_q;
    logic          b_edge;
    logic [TW-1:0] tmr;
    logic          tick;
    logic [3:0]    units;
    logic [3:0]    units_nx;
    logic          is_dash;
    logic          gap_done;
    logic          wgap_done;
    logic [4:0]    sym_code;
    logic [2:0]    sym_len;
    logic          sym_err;
    logic [7:0]    letter_word;
    logic          emit_pend;
    logic [7:0]    emit_data;

    // The tick landing on the same cycle as a key edge still counts, so an
    // interval of exactly N units is seen as N completed units.
    always_comb begin
        b_edge      = b ^ b_q;
        tick        = (tmr == '0);
        units_nx    = (tick && (units != UNIT_MAX)) ? units + 4'd1 : units;
        is_dash     = (units_nx >= DASH_MIN);
        gap_done    = tick && (units_nx == LETTER_GAP);
        wgap_done   = tick && (units_nx == WORD_GAP);
        letter_word = sym_err ? ERR_WORD : {sym_len, sym_code};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q   <= 1'b1;
            tmr   <= '0;
            units <= '0;
        end else begin
            b_q <= b;
            if (b_edge || tick) begin
                tmr <= TMR_LOAD;
            end else begin
                tmr <= tmr - 1'b1;
            end
            units <= b_edge ? 4'd0 : units_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sym_code  <= '0;
            sym_len   <= '0;
            sym_err   <= 1'b0;
            emit_pend <= 1'b0;
            emit_data <= '0;
        end else begin
            emit_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (!b) begin
                        state <= PRESS;
                    end
                end
                PRESS: begin
                    if (b) begin
                        // A sixth symbol only flags the error; the letter stays at five.
                        if (sym_len == 3'd5) begin
                            sym_err <= 1'b1;
                        end else begin
                            sym_code <= {sym_code[3:0], is_dash};
                            sym_len  <= sym_len + 3'd1;
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        emit_pend <= 1'b1;
                        emit_data <= letter_word;
                        sym_code  <= '0;
                        sym_len   <= '0;
                        sym_err   <= 1'b0;
                        state     <= b ? WGAP : PRESS;
                    end else if (!b) begin
                        state <= PRESS;
                    end
                end
                WGAP: begin
                    if (wgap_done) begin
                        emit_pend <= 1'b1;
                        emit_data <= SPACE_WORD;
                        state     <= b ? IDLE : PRESS;
                    end else if (!b) begin
                        state <= PRESS;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO suppresses the strobe for that single cycle; nothing is retried.
    assign wr_en   = emit_pend & ~wr_full;
    assign wr_data = emit_data;
    assign busy    = (state == PRESS) || (state == GAP);

`ifdef MORSE_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (emit_pend && wr_full && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule
